// File: rtl/mem_cycle_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer driving MAR/MDR and the MOV/MOC handshake.
// Optional access watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_cycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [2:0] opcode,
    input  logic       MOC,
    output logic       MOV,
    output logic       RW,
    output logic       MAREnable,
    output logic       mar_sel,
    output logic       MDREnable,
    output logic       mdr_sel,
    output logic       ir_load,
    output logic       pc_load,
    output logic       reg_write,
    output logic [2:0] state,
    output logic       bus_error
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_ADDR = 3'd1,
        FETCH_MEM  = 3'd2,
        DECODE     = 3'd3,
        EXEC       = 3'd4,
        MEM_ADDR   = 3'd5,
        MEM_ACC    = 3'd6,
        WB         = 3'd7
    } state_t;

    state_t cur_state, nxt_state, end_state;
    logic   is_lw, is_sw;
    logic   timed_out, idle_block;

    assign is_lw     = (opcode == 3'b100);
    assign is_sw     = (opcode == 3'b101);
    assign end_state = run ? FETCH_ADDR : IDLE;
    assign state     = cur_state;

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;
    logic             err_flag;
    logic             waiting;

    assign waiting   = (cur_state == FETCH_MEM) || (cur_state == MEM_ACC);
    assign timed_out = waiting && !MOC && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter is zero whenever we are outside a wait state, so every access starts fresh.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            if (waiting && !MOC)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (timed_out)
                err_flag <= 1'b1;
        end
    end

    assign bus_error  = err_flag;
    assign idle_block = err_flag;
`else
    assign timed_out  = 1'b0;
    assign idle_block = 1'b0;
    assign bus_error  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cur_state <= IDLE;
        else
            cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        MOV       = 1'b0;
        RW        = 1'b0;
        MAREnable = 1'b0;
        mar_sel   = 1'b0;
        MDREnable = 1'b0;
        mdr_sel   = 1'b0;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        reg_write = 1'b0;
        case (cur_state)
            IDLE: begin
                if (run && !idle_block)
                    nxt_state = FETCH_ADDR;
            end
            FETCH_ADDR: begin
                MAREnable = 1'b1;
                nxt_state = FETCH_MEM;
            end
            FETCH_MEM: begin
                MOV       = 1'b1;
                RW        = 1'b1;
                MDREnable = MOC;
                if (MOC)
                    nxt_state = DECODE;
                else if (timed_out)
                    nxt_state = IDLE;
            end
            DECODE: begin
                ir_load   = 1'b1;
                pc_load   = 1'b1;
                nxt_state = EXEC;
            end
            EXEC: begin
                if (is_lw || is_sw) begin
                    nxt_state = MEM_ADDR;
                end else begin
                    // 010 and 110 produce no register result
                    reg_write = !((opcode == 3'b010) || (opcode == 3'b110));
                    nxt_state = end_state;
                end
            end
            MEM_ADDR: begin
                MAREnable = 1'b1;
                mar_sel   = 1'b1;
                if (is_sw) begin
                    MDREnable = 1'b1;
                    mdr_sel   = 1'b1;
                end
                nxt_state = MEM_ACC;
            end
            MEM_ACC: begin
                MOV = 1'b1;
                RW  = is_lw;
                if (is_lw)
                    MDREnable = MOC;
                if (MOC)
                    nxt_state = is_lw ? WB : end_state;
                else if (timed_out)
                    nxt_state = IDLE;
            end
            WB: begin
                reg_write = 1'b1;
                nxt_state = end_state;
            end
            default: nxt_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Directed table-driven bench for mem_cycle_sequencer plus hand sequences for reset and wait/timeout.
module tb_mem_cycle_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic [2:0] opcode;
    logic       MOC;
    logic       MOV, RW, MAREnable, mar_sel, MDREnable, mdr_sel;
    logic       ir_load, pc_load, reg_write, bus_error;
    logic [2:0] state;
    logic [9:0] obs;

    int errors = 0;
    int checks = 0;

    mem_cycle_sequencer #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .MOC(MOC),
        .MOV(MOV), .RW(RW), .MAREnable(MAREnable), .mar_sel(mar_sel),
        .MDREnable(MDREnable), .mdr_sel(mdr_sel), .ir_load(ir_load),
        .pc_load(pc_load), .reg_write(reg_write), .state(state), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    // {MOV,RW,MAREnable,mar_sel,MDREnable,mdr_sel,ir_load,pc_load,reg_write,bus_error}
    assign obs = {MOV, RW, MAREnable, mar_sel, MDREnable, mdr_sel, ir_load, pc_load, reg_write, bus_error};

    typedef struct {
        logic       run;
        logic [2:0] opc;
        logic       moc;
        logic [2:0] st;
        logic [9:0] outs;
        string      name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [2:0] o, input logic m,
                       input logic [2:0] s, input logic [9:0] e, input string n);
        vec_t v;
        v.run = r; v.opc = o; v.moc = m; v.st = s; v.outs = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; run = 1'b0; MOC = 1'b0; opcode = 3'b000;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Enters FETCH_MEM and stalls 16 cycles; MOC optionally asserted on the 16th.
    task automatic run_wait(input logic moc_last, input logic [2:0] exp_st, input logic exp_err);
        @(negedge clk);
        run = 1'b1; MOC = 1'b0; opcode = 3'b000;
        @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (i == 16) MOC = moc_last;
            #1;
            if (i == 1 || i == 16) chk($sformatf("wait_state_%0d", i), 32'(state), 32'd2);
        end
        @(negedge clk);
        MOC = 1'b0;
        #1;
        chk("after_wait_state", 32'(state), 32'(exp_st));
        chk("after_wait_bus_error", 32'(bus_error), 32'(exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; run = 1'b0; opcode = 3'b000; MOC = 1'b0;
        #12;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_outs", 32'(obs), 32'd0);

        // add (000), run high, immediate MOC
        add(0, 3'b000, 0, 3'd0, 10'b0000000000, "idle_hold");
        add(1, 3'b000, 1, 3'd0, 10'b0000000000, "idle_go_moc_ignored");
        add(1, 3'b000, 0, 3'd1, 10'b0010000000, "add_fetch_addr");
        add(1, 3'b000, 1, 3'd2, 10'b1100100000, "add_fetch_mem");
        add(1, 3'b000, 0, 3'd3, 10'b0000001100, "add_decode");
        add(1, 3'b000, 0, 3'd4, 10'b0000000010, "add_exec");
        // sw (101), immediate MOC
        add(1, 3'b101, 0, 3'd1, 10'b0010000000, "sw_fetch_addr");
        add(1, 3'b101, 1, 3'd2, 10'b1100100000, "sw_fetch_mem");
        add(1, 3'b101, 0, 3'd3, 10'b0000001100, "sw_decode");
        add(1, 3'b101, 0, 3'd4, 10'b0000000000, "sw_exec");
        add(1, 3'b101, 0, 3'd5, 10'b0011110000, "sw_mem_addr");
        add(1, 3'b101, 1, 3'd6, 10'b1000000000, "sw_mem_acc");
        // 010: no register write
        add(1, 3'b010, 0, 3'd1, 10'b0010000000, "op2_fetch_addr");
        add(1, 3'b010, 1, 3'd2, 10'b1100100000, "op2_fetch_mem");
        add(1, 3'b010, 0, 3'd3, 10'b0000001100, "op2_decode");
        add(1, 3'b010, 0, 3'd4, 10'b0000000000, "op2_exec");
        // lw (100), MOC after 3 wait cycles per access, run dropped during MEM_ACC
        add(1, 3'b100, 0, 3'd1, 10'b0010000000, "lw_fetch_addr");
        add(1, 3'b100, 0, 3'd2, 10'b1100000000, "lw_fetch_wait1");
        add(1, 3'b100, 0, 3'd2, 10'b1100000000, "lw_fetch_wait2");
        add(1, 3'b100, 0, 3'd2, 10'b1100000000, "lw_fetch_wait3");
        add(1, 3'b100, 1, 3'd2, 10'b1100100000, "lw_fetch_moc");
        add(1, 3'b100, 0, 3'd3, 10'b0000001100, "lw_decode");
        add(1, 3'b100, 0, 3'd4, 10'b0000000000, "lw_exec");
        add(1, 3'b100, 0, 3'd5, 10'b0011000000, "lw_mem_addr");
        add(0, 3'b100, 0, 3'd6, 10'b1100000000, "lw_acc_wait1");
        add(0, 3'b100, 0, 3'd6, 10'b1100000000, "lw_acc_wait2");
        add(0, 3'b100, 0, 3'd6, 10'b1100000000, "lw_acc_wait3");
        add(0, 3'b100, 1, 3'd6, 10'b1100100000, "lw_acc_moc");
        add(0, 3'b100, 0, 3'd7, 10'b0000000010, "lw_wb");
        add(0, 3'b100, 1, 3'd0, 10'b0000000000, "idle_moc_pulse");
        add(0, 3'b100, 0, 3'd0, 10'b0000000000, "idle_after_pulse");
        // 111 writes, then ends to IDLE with run low
        add(1, 3'b111, 0, 3'd0, 10'b0000000000, "op7_idle_go");
        add(1, 3'b111, 0, 3'd1, 10'b0010000000, "op7_fetch_addr");
        add(1, 3'b111, 1, 3'd2, 10'b1100100000, "op7_fetch_mem");
        add(1, 3'b111, 0, 3'd3, 10'b0000001100, "op7_decode");
        add(0, 3'b111, 0, 3'd4, 10'b0000000010, "op7_exec");
        // 110 does not write
        add(1, 3'b110, 0, 3'd0, 10'b0000000000, "op6_idle_go");
        add(1, 3'b110, 0, 3'd1, 10'b0010000000, "op6_fetch_addr");
        add(1, 3'b110, 1, 3'd2, 10'b1100100000, "op6_fetch_mem");
        add(1, 3'b110, 0, 3'd3, 10'b0000001100, "op6_decode");
        add(0, 3'b110, 0, 3'd4, 10'b0000000000, "op6_exec");
        add(0, 3'b110, 0, 3'd0, 10'b0000000000, "op6_idle");

        @(negedge clk);
        reset_n = 1'b1;
        foreach (vecs[k]) begin
            @(negedge clk);
            run = vecs[k].run; opcode = vecs[k].opc; MOC = vecs[k].moc;
            #1;
            chk({vecs[k].name, "_state"}, 32'(state), 32'(vecs[k].st));
            chk({vecs[k].name, "_outs"}, 32'(obs), 32'(vecs[k].outs));
        end

        // Asynchronous reset while MOV is high
        @(negedge clk);
        run = 1'b1; MOC = 1'b0; opcode = 3'b000;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("pre_reset_mov", 32'(MOV), 32'd1);
        chk("pre_reset_state", 32'(state), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("async_reset_mov", 32'(MOV), 32'd0);
        chk("async_reset_state", 32'(state), 32'd0);
        @(negedge clk);
        reset_n = 1'b1; run = 1'b0;

`ifdef MEM_TIMEOUT_EN
        do_reset();
        run_wait(1'b0, 3'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            run = 1'b1;
            #1;
        end
        chk("sticky_state", 32'(state), 32'd0);
        chk("sticky_bus_error", 32'(bus_error), 32'd1);
        do_reset();
        #1;
        chk("reset_clears_bus_error", 32'(bus_error), 32'd0);
        run_wait(1'b1, 3'd3, 1'b0);
`else
        do_reset();
        run_wait(1'b0, 3'd2, 1'b0);
        @(negedge clk);
        MOC = 1'b1;
        #1;
        chk("late_moc_mdr_enable", 32'(MDREnable), 32'd1);
        @(negedge clk);
        MOC = 1'b0;
        #1;
        chk("late_moc_decode", 32'(state), 32'd3);
        chk("late_moc_bus_error", 32'(bus_error), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
